coin_collect_ctrl: RTL and testbench

// - Upstream of the coin-erase animator: scans the coin table once per frame.
// - Flags every live coin overlapping the player.
// - For each hit: clears the coin's exist bit in the table, increments the score,
//   and drives {exist,x,y} plus an erase enable to the erase stage.
// - Sits between the player-position logic, the coin-table RAM and the erase/VGA path.

---
 rtl/coin_collect_ctrl.sv | 166 ++++++++++++++++
 tb/tb_coin_collect_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_collect_ctrl.sv
// coin_collect_ctrl
// Scans the coin table once per frame. Every live coin that overlaps the player
// (within +/-1 pixel on both axes) is cleared in the table, counted into the score,
// and handed to the erase stage for ERASE_CYCLES cycles.
//
// Ports
//   clock, resetn       rising-edge clock, asynchronous active-low reset
//   scan_start          one-cycle pulse; starts a scan when idle, otherwise ignored
//   player_x/player_y   player position, latched on the accepted scan_start
//   coin_addr           coin-table address (read and write)
//   coin_rdata          table read data {exist,x,y}, one-cycle read latency
//   coin_we/coin_wdata  table write strobe and data (exist bit cleared)
//   memQout             {exist,x,y} of the coin being erased
//   coinErase_en        erase request, high for ERASE_CYCLES cycles per hit
//   score               saturating count of collected coins
//   all_collected       sticky flag, set once NUM_COINS coins have been collected
//   busy, done          scan in progress / one-cycle end-of-scan pulse
module coin_collect_ctrl #(
    parameter int unsigned NUM_COINS    = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned SCORE_W      = 8,
    parameter int unsigned ERASE_CYCLES = 5
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               scan_start,
    input  logic [7:0]         player_x,
    input  logic [6:0]         player_y,
    output logic [ADDR_W-1:0]  coin_addr,
    input  logic [15:0]        coin_rdata,
    output logic               coin_we,
    output logic [15:0]        coin_wdata,
    output logic [15:0]        memQout,
    output logic               coinErase_en,
    output logic [SCORE_W-1:0] score,
    output logic               all_collected,
    output logic               busy,
    output logic               done
);
    localparam int unsigned CntW = $clog2(NUM_COINS + 1);
    localparam int unsigned EcW  = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_COINS - 1);
    localparam logic [EcW-1:0]    LastEc  = EcW'(ERASE_CYCLES - 1);
    localparam logic [CntW-1:0]   FullCnt = CntW'(NUM_COINS);

    typedef enum logic [2:0] {StIdle, StRd, StChk, StClr, StErase, StDone} state_e;

    state_e             state_q;
    logic [7:0]         px_q;
    logic [6:0]         py_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [EcW-1:0]     erase_cnt_q;
    logic [CntW-1:0]    cnt_q;
    logic [SCORE_W-1:0] score_q;
    logic               we_q;
    logic [15:0]        wdata_q;
    logic [15:0]        memq_q;
    logic               erase_q;
    logic               all_q;
    logic               done_q;

    logic [8:0] dx;
    logic [7:0] dy;
    logic       hit;
    logic       last;

    // Differences are taken one bit wider than the operands so that 0 vs max
    // does not alias to a neighbour; -1 shows up as all-ones.
    always_comb begin
        dx   = {1'b0, px_q} - {1'b0, coin_rdata[14:7]};
        dy   = {1'b0, py_q} - {1'b0, coin_rdata[6:0]};
        hit  = coin_rdata[15]
             && ((dx == 9'd0) || (dx == 9'd1) || (dx == 9'h1FF))
             && ((dy == 8'd0) || (dy == 8'd1) || (dy == 8'hFF));
        last = (idx_q == LastIdx);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            px_q        <= '0;
            py_q        <= '0;
            idx_q       <= '0;
            erase_cnt_q <= '0;
            cnt_q       <= '0;
            score_q     <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            memq_q      <= '0;
            erase_q     <= 1'b0;
            all_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (scan_start) begin
                        px_q    <= player_x;
                        py_q    <= player_y;
                        idx_q   <= '0;
                        state_q <= StRd;
                    end
                end
                StRd: state_q <= StChk;
                StChk: begin
                    // Table data is captured here, while it is still the entry at idx.
                    if (hit) begin
                        we_q    <= 1'b1;
                        wdata_q <= {1'b0, coin_rdata[14:0]};
                        memq_q  <= {1'b1, coin_rdata[14:0]};
                        state_q <= StClr;
                    end else if (last) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StRd;
                    end
                end
                StClr: begin
                    if (score_q != '1) begin
                        score_q <= score_q + 1'b1;
                    end
                    if (cnt_q != FullCnt) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == FullCnt - 1'b1) begin
                            all_q <= 1'b1;
                        end
                    end
                    erase_q     <= 1'b1;
                    erase_cnt_q <= '0;
                    state_q     <= StErase;
                end
                StErase: begin
                    if (erase_cnt_q == LastEc) begin
                        erase_q <= 1'b0;
                        if (last) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= StRd;
                        end
                    end else begin
                        erase_cnt_q <= erase_cnt_q + 1'b1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign coin_addr     = idx_q;
    assign coin_we       = we_q;
    assign coin_wdata    = wdata_q;
    assign memQout       = memq_q;
    assign coinErase_en  = erase_q;
    assign score         = score_q;
    assign all_collected = all_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;

endmodule

// File: tb/tb_coin_collect_ctrl.sv
// Bench for coin_collect_ctrl: a clocked coin-table model with one-cycle read
// latency, a table of single-coin scans, and directed multi-cycle sequences.
module tb_coin_collect_ctrl;
    logic        clock;
    logic        resetn;
    logic        scan_start;
    logic [7:0]  player_x;
    logic [6:0]  player_y;
    logic [3:0]  coin_addr;
    logic [15:0] coin_rdata;
    logic        coin_we;
    logic [15:0] coin_wdata;
    logic [15:0] memQout;
    logic        coinErase_en;
    logic [7:0]  score;
    logic        all_collected;
    logic        busy;
    logic        done;

    // Second instance: 4 coins, 2-bit score, for saturation and all_collected.
    logic        scan_start2;
    logic [1:0]  coin_addr_s;
    logic [15:0] coin_rdata_s;
    logic        coin_we_s;
    logic [15:0] coin_wdata_s;
    logic [15:0] memQout_s;
    logic        erase_s;
    logic [1:0]  score_s;
    logic        all_s;
    logic        busy_s;
    logic        done_s;

    logic [15:0] mem  [16];
    logic [15:0] mem2 [4];
    logic        fill_en;
    logic [15:0] fill_data;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;

    int n_cmp;
    int n_err;
    int exp_score;

    coin_collect_ctrl u_dut (
        .clock        (clock),
        .resetn       (resetn),
        .scan_start   (scan_start),
        .player_x     (player_x),
        .player_y     (player_y),
        .coin_addr    (coin_addr),
        .coin_rdata   (coin_rdata),
        .coin_we      (coin_we),
        .coin_wdata   (coin_wdata),
        .memQout      (memQout),
        .coinErase_en (coinErase_en),
        .score        (score),
        .all_collected(all_collected),
        .busy         (busy),
        .done         (done)
    );

    coin_collect_ctrl #(
        .NUM_COINS   (4),
        .ADDR_W      (2),
        .SCORE_W     (2),
        .ERASE_CYCLES(5)
    ) u_sat (
        .clock        (clock),
        .resetn       (resetn),
        .scan_start   (scan_start2),
        .player_x     (player_x),
        .player_y     (player_y),
        .coin_addr    (coin_addr_s),
        .coin_rdata   (coin_rdata_s),
        .coin_we      (coin_we_s),
        .coin_wdata   (coin_wdata_s),
        .memQout      (memQout_s),
        .coinErase_en (erase_s),
        .score        (score_s),
        .all_collected(all_s),
        .busy         (busy_s),
        .done         (done_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        coin_rdata <= mem[coin_addr];
        if (fill_en) begin
            for (int i = 0; i < 16; i++) mem[i] <= fill_data;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (coin_we) begin
            mem[coin_addr] <= coin_wdata;
        end
    end

    always @(posedge clock) begin
        coin_rdata_s <= mem2[coin_addr_s];
        if (fill_en) begin
            for (int i = 0; i < 4; i++) mem2[i] <= fill_data;
        end else if (coin_we_s) begin
            mem2[coin_addr_s] <= coin_wdata_s;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tbl_fill(input logic [15:0] d);
        @(negedge clock);
        fill_en   = 1'b1;
        fill_data = d;
        @(negedge clock);
        fill_en   = 1'b0;
    endtask

    task automatic tbl_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clock);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clock);
        ld_en   = 1'b0;
    endtask

    // Cycle 0 is the cycle in which scan_start is sampled.
    task automatic run_scan(input logic [7:0] px, input logic [6:0] py, input bit repulse,
                            output int done_cyc, output int done_cnt, output int we_cnt,
                            output int er_cnt, output logic [3:0] waddr,
                            output logic [15:0] wdata, output logic [15:0] mq,
                            output bit mq_unstable, output logic busy_after);
        done_cyc = -1; done_cnt = 0; we_cnt = 0; er_cnt = 0;
        waddr = '0; wdata = '0; mq = '0; mq_unstable = 1'b0; busy_after = 1'b1;
        @(negedge clock);
        player_x   = px;
        player_y   = py;
        scan_start = 1'b1;
        for (int c = 1; c < 400; c++) begin
            @(negedge clock);
            scan_start = repulse && (c == 5 || c == 33);
            if (coin_we) begin
                we_cnt++;
                waddr = coin_addr;
                wdata = coin_wdata;
            end
            if (coinErase_en) begin
                if (er_cnt == 0) mq = memQout;
                else if (memQout !== mq) mq_unstable = 1'b1;
                er_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy;
            if (done_cyc >= 0 && c == done_cyc + 3) break;
        end
        scan_start = 1'b0;
    endtask

    typedef struct {
        logic       ex;
        logic [3:0] idx;
        logic [7:0] cx;
        logic [6:0] cy;
        logic [7:0] px;
        logic [6:0] py;
        logic       hit;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, dn, wc, ec;
        logic [3:0]  wa;
        logic [15:0] wd, mq, word;
        bit          mqu;
        logic        ba;
        int          live;
        int          sat_cyc;

        vecs[0] = '{1'b0, 4'd5,  8'd40,  7'd30,  8'd40,  7'd30,  1'b0};
        vecs[1] = '{1'b1, 4'd5,  8'd40,  7'd30,  8'd41,  7'd31,  1'b1};
        vecs[2] = '{1'b1, 4'd5,  8'd40,  7'd30,  8'd42,  7'd30,  1'b0};
        vecs[3] = '{1'b1, 4'd0,  8'd0,   7'd0,   8'd0,   7'd0,   1'b1};
        vecs[4] = '{1'b1, 4'd0,  8'd0,   7'd0,   8'd255, 7'd0,   1'b0};
        vecs[5] = '{1'b1, 4'd15, 8'd255, 7'd127, 8'd254, 7'd126, 1'b1};
        vecs[6] = '{1'b1, 4'd7,  8'd100, 7'd50,  8'd99,  7'd49,  1'b1};
        vecs[7] = '{1'b1, 4'd7,  8'd100, 7'd50,  8'd100, 7'd52,  1'b0};
        vecs[8] = '{1'b1, 4'd3,  8'd10,  7'd0,   8'd10,  7'd127, 1'b0};
        vecs[9] = '{1'b1, 4'd2,  8'd20,  7'd20,  8'd19,  7'd21,  1'b1};

        n_cmp = 0; n_err = 0; exp_score = 0;
        resetn = 1'b0; scan_start = 1'b0; scan_start2 = 1'b0;
        player_x = '0; player_y = '0;
        fill_en = 1'b0; fill_data = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clock);

        check("rst_busy", busy, 0);
        check("rst_erase", coinErase_en, 0);
        check("rst_out", {coin_we, done, all_collected, score, coin_addr}, 0);
        check("rst_memq", memQout, 0);
        resetn = 1'b1;

        // Saturating 2-bit score: four hits in a 4-coin table.
        tbl_fill({1'b1, 8'd10, 7'd10});
        @(negedge clock);
        player_x = 8'd10; player_y = 7'd10; scan_start2 = 1'b1;
        sat_cyc = -1;
        for (int c = 1; c < 200; c++) begin
            @(negedge clock);
            scan_start2 = 1'b0;
            if (done_s) begin
                sat_cyc = c;
                break;
            end
        end
        check("sat_done_cycle", sat_cyc, 33);
        check("sat_score", score_s, 3);
        check("sat_all_collected", all_s, 1);

        foreach (vecs[i]) begin
            tbl_fill(16'h0000);
            word = {vecs[i].ex, vecs[i].cx, vecs[i].cy};
            tbl_write(vecs[i].idx, word);
            run_scan(vecs[i].px, vecs[i].py, 1'b0, dc, dn, wc, ec, wa, wd, mq, mqu, ba);
            if (vecs[i].hit) exp_score++;
            check($sformatf("v%0d_done_cycle", i), dc, vecs[i].hit ? 39 : 33);
            check($sformatf("v%0d_done_pulses", i), dn, 1);
            check($sformatf("v%0d_we_count", i), wc, vecs[i].hit ? 1 : 0);
            check($sformatf("v%0d_erase_cycles", i), ec, vecs[i].hit ? 5 : 0);
            check($sformatf("v%0d_score", i), score, exp_score);
            check($sformatf("v%0d_busy_after", i), ba, 0);
            check($sformatf("v%0d_table", i), mem[vecs[i].idx],
                  vecs[i].hit ? {1'b0, vecs[i].cx, vecs[i].cy} : word);
            if (vecs[i].hit) begin
                check($sformatf("v%0d_waddr", i), wa, vecs[i].idx);
                check($sformatf("v%0d_wdata", i), wd, {1'b0, vecs[i].cx, vecs[i].cy});
                check($sformatf("v%0d_memq", i), mq, {1'b1, vecs[i].cx, vecs[i].cy});
                check($sformatf("v%0d_memq_stable", i), mqu, 0);
                check($sformatf("v%0d_memq_hold", i), memQout,
                      {1'b1, vecs[i].cx, vecs[i].cy});
            end
        end

        // scan_start re-pulsed mid-scan and in DONE must not start another scan.
        tbl_fill(16'h0000);
        run_scan(8'd1, 7'd1, 1'b1, dc, dn, wc, ec, wa, wd, mq, mqu, ba);
        check("repulse_done_cycle", dc, 33);
        check("repulse_done_pulses", dn, 1);
        check("repulse_busy_after", ba, 0);
        check("pre_all_collected", all_collected, 0);

        // Every entry hit: back-to-back service, all_collected sets.
        tbl_fill({1'b1, 8'd50, 7'd50});
        run_scan(8'd50, 7'd50, 1'b0, dc, dn, wc, ec, wa, wd, mq, mqu, ba);
        exp_score += 16;
        check("all16_done_cycle", dc, 33 + 16 * 6);
        check("all16_we_count", wc, 16);
        check("all16_erase_cycles", ec, 80);
        check("all16_score", score, exp_score);
        check("all16_all_collected", all_collected, 1);
        live = 0;
        for (int i = 0; i < 16; i++) live += int'(mem[i][15]);
        check("all16_live_left", live, 0);

        // Reset on the second erase cycle of a hit at idx 0.
        tbl_fill(16'h0000);
        tbl_write(4'd0, {1'b1, 8'd0, 7'd0});
        @(negedge clock);
        player_x = 8'd0; player_y = 7'd0; scan_start = 1'b1;
        @(negedge clock);
        scan_start = 1'b0;
        repeat (4) @(negedge clock);
        check("midrst_erase_before", coinErase_en, 1);
        resetn = 1'b0;
        #1;
        check("midrst_erase", coinErase_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_score", score, 0);
        check("midrst_all_collected", all_collected, 0);
        check("midrst_memq", memQout, 0);
        @(negedge clock);
        resetn = 1'b1;
        exp_score = 0;
        repeat (2) @(negedge clock);
        check("midrst_idle_after", busy, 0);

        // The interrupted hit had already cleared the entry, so this scan is empty.
        run_scan(8'd0, 7'd0, 1'b0, dc, dn, wc, ec, wa, wd, mq, mqu, ba);
        check("post_rst_done_cycle", dc, 33);
        check("post_rst_we_count", wc, 0);
        check("post_rst_erase_cycles", ec, 0);
        check("post_rst_score", score, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
